// File: rtl/pipe_stage_buf_pkg.sv
// Shared state encoding, occupancy constants and saturating-increment helper
// for the inter-stage pipeline buffer. sat_inc supports widths up to 64 bits.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    localparam int unsigned SAT_MAX_W = 64;

    // Increment value, holding at 2^width-1; callers truncate the result to their width.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                     input int unsigned           width);
        logic [SAT_MAX_W-1:0] max_val;
        max_val = (width >= SAT_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? max_val : value + 64'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating performance counter with synchronous reset and clear.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= CNT_W'(sat_inc(SAT_MAX_W'(r_count), CNT_W));
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline-stage buffer with optional 2-entry skid, synchronous
// flush and saturating stall/flush counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              cnt_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    pipe_state_t       r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_in_ready;

    logic              w_out_valid;
    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;
    logic [1:0]        w_occ;
    logic              w_stall_inc;
    logic              w_flush_drop;

    always_comb begin
        w_out_valid = (r_state != ST_EMPTY);
        w_in_ready  = (SKID != 0) ? r_in_ready : (!w_out_valid || out_ready);
        w_in_fire   = in_valid && w_in_ready;
        w_out_fire  = w_out_valid && out_ready;
    end

    always_comb begin
        case (r_state)
            ST_ONE:  w_occ = OCC_ONE;
            ST_TWO:  w_occ = OCC_TWO;
            default: w_occ = OCC_EMPTY;
        endcase
    end

    // A flush only counts if something held is lost, i.e. not delivered in the same cycle.
    always_comb begin
        w_flush_drop = flush && (w_occ > {1'b0, w_out_fire});
        w_stall_inc  = w_out_valid && !out_ready && !flush;
    end

    // With SKID=0 an in_fire in ST_ONE implies out_fire, so ST_TWO is never entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_main  <= in_data;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= in_data;
                    end else if (w_in_fire) begin
                        r_skid     <= in_data;
                        r_state    <= ST_TWO;
                        r_in_ready <= 1'b0;
                    end else if (w_out_fire) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        r_main     <= r_skid;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main;
    assign occupancy = w_occ;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (w_flush_drop),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: scoreboarded SKID=1 instance plus directed checks
// on a SKID=0 instance and a CNT_W=2 instance.
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Main instance: SKID=1, DATA_W=32, CNT_W=16
    logic        flush = 1'b0, cnt_clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt, flush_cnt;

    pipe_stage_buf #(.DATA_W(32), .SKID(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // SKID=0 instance
    logic        s0_flush = 1'b0, s0_clr = 1'b0, s0_in_valid = 1'b0, s0_out_ready = 1'b0;
    logic [7:0]  s0_in_data = '0;
    logic        s0_in_ready, s0_out_valid;
    logic [7:0]  s0_out_data;
    logic [1:0]  s0_occ;
    logic [15:0] s0_stall, s0_flushc;

    pipe_stage_buf #(.DATA_W(8), .SKID(0), .CNT_W(16)) dut_s0 (
        .clk(clk), .rst(rst), .flush(s0_flush), .cnt_clr(s0_clr),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
        .occupancy(s0_occ), .stall_cnt(s0_stall), .flush_cnt(s0_flushc)
    );

    // Narrow-counter instance: CNT_W=2
    logic       st_flush = 1'b0, st_clr = 1'b0, st_in_valid = 1'b0, st_out_ready = 1'b0;
    logic [7:0] st_in_data = '0;
    logic       st_in_ready, st_out_valid;
    logic [7:0] st_out_data;
    logic [1:0] st_occ;
    logic [1:0] st_stall, st_flushc;

    pipe_stage_buf #(.DATA_W(8), .SKID(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(st_flush), .cnt_clr(st_clr),
        .in_valid(st_in_valid), .in_ready(st_in_ready), .in_data(st_in_data),
        .out_valid(st_out_valid), .out_ready(st_out_ready), .out_data(st_out_data),
        .occupancy(st_occ), .stall_cnt(st_stall), .flush_cnt(st_flushc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the main instance: accepted words in, delivered words out.
    logic [31:0] sb_q[$];

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual=0x%0h required=<no word pending>", out_data);
                end else begin
                    chk("sb_data", 64'(out_data), 64'(sb_q.pop_front()));
                end
            end
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back(in_data);
        end
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
        chk("rst_s0_in_ready", 64'(s0_in_ready), 64'd1);
        rst = 1'b0;

        // Streaming 0x1..0x8 with downstream always ready
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            tick();
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_data", 64'(out_data), 64'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", 64'(out_valid), 64'd0);
        chk("stream_stall_cnt", 64'(stall_cnt), 64'd0);

        // Skid fill: A, B accepted under back-pressure, C held upstream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        chk("skid_a_data", 64'(out_data), 64'hA);
        chk("skid_a_ready", 64'(in_ready), 64'd1);
        in_data = 32'hB;
        tick();
        chk("skid_two_occ", 64'(occupancy), 64'd2);
        chk("skid_two_ready", 64'(in_ready), 64'd0);
        chk("skid_two_stall", 64'(stall_cnt), 64'd1);
        in_data = 32'hC;
        tick();
        chk("skid_hold_occ", 64'(occupancy), 64'd2);
        chk("skid_hold_ready", 64'(in_ready), 64'd0);
        chk("skid_hold_data", 64'(out_data), 64'hA);
        out_ready = 1'b1;
        tick();
        chk("skid_rel_data", 64'(out_data), 64'hB);
        chk("skid_rel_occ", 64'(occupancy), 64'd1);
        chk("skid_rel_ready", 64'(in_ready), 64'd1);
        tick();
        chk("skid_c_data", 64'(out_data), 64'hC);
        in_valid = 1'b0;
        tick();
        chk("skid_drained", 64'(out_valid), 64'd0);
        chk("skid_stall_cnt", 64'(stall_cnt), 64'd2);

        // Flush in ST_TWO with a concurrent input word
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        chk("fl_pre_occ", 64'(occupancy), 64'd2);
        in_data = 32'h33;
        flush   = 1'b1;
        tick();
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_occ", 64'(occupancy), 64'd0);
        chk("fl_flush_cnt", 64'(flush_cnt), 64'd1);
        chk("fl_stall_cnt", 64'(stall_cnt), 64'd3);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("fl_word_dropped", 64'(out_valid), 64'd0);

        // Flush while the only entry is being delivered: nothing lost
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h44;
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        chk("fl_deliv_cnt", 64'(flush_cnt), 64'd1);
        chk("fl_deliv_valid", 64'(out_valid), 64'd0);

        // Flush dropping a single stalled entry
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h45;
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_one_cnt", 64'(flush_cnt), 64'd2);
        chk("fl_one_stall", 64'(stall_cnt), 64'd3);

        // Reset together with flush while in ST_TWO
        in_valid = 1'b1;
        in_data  = 32'h55;
        tick();
        in_data = 32'h66;
        tick();
        chk("rf_pre_occ", 64'(occupancy), 64'd2);
        in_data = 32'h77;
        rst     = 1'b1;
        flush   = 1'b1;
        tick();
        chk("rf_out_valid", 64'(out_valid), 64'd0);
        chk("rf_out_data", 64'(out_data), 64'd0);
        chk("rf_occ", 64'(occupancy), 64'd0);
        chk("rf_in_ready", 64'(in_ready), 64'd1);
        chk("rf_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rf_flush_cnt", 64'(flush_cnt), 64'd0);
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;

        // SKID=0: combinational ready and replace-on-concurrent-fire
        s0_out_ready = 1'b0;
        s0_in_valid  = 1'b1;
        s0_in_data   = 8'h71;
        tick();
        chk("s0_one_ready", 64'(s0_in_ready), 64'd0);
        chk("s0_one_data", 64'(s0_out_data), 64'h71);
        chk("s0_one_occ", 64'(s0_occ), 64'd1);
        s0_in_data = 8'h72;
        tick();
        chk("s0_hold_data", 64'(s0_out_data), 64'h71);
        s0_out_ready = 1'b1;
        #1;
        chk("s0_comb_ready", 64'(s0_in_ready), 64'd1);
        tick();
        chk("s0_replace_data", 64'(s0_out_data), 64'h72);
        chk("s0_replace_occ", 64'(s0_occ), 64'd1);
        s0_in_valid = 1'b0;
        tick();
        chk("s0_drained", 64'(s0_out_valid), 64'd0);
        chk("s0_stall_cnt", 64'(s0_stall), 64'd1);

        // CNT_W=2 saturation, then clear beating a concurrent stall
        st_out_ready = 1'b0;
        st_in_valid  = 1'b1;
        st_in_data   = 8'h05;
        tick();
        st_in_valid = 1'b0;
        repeat (6) tick();
        chk("sat_stall_max", 64'(st_stall), 64'd3);
        st_clr = 1'b1;
        tick();
        chk("sat_clr", 64'(st_stall), 64'd0);
        st_clr = 1'b0;
        tick();
        chk("sat_resume", 64'(st_stall), 64'd1);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
